serial_frame_capture: RTL

// Downstream consumer of the counter/memory/mux serial stage. Samples the 1-bit serial stream, one bit per

---
 rtl/serial_frame_capture.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_frame_capture.sv
// ============================================================================
// Module      : serial_frame_capture
// Description : Samples a 1-bit serial stream (one bit per counter step),
//               assembles FRAME_LEN bits into a parallel frame word plus its
//               ones-count, and hands the frame off through a 1-entry
//               valid/ready output buffer. Tracks dropped frames (sticky
//               overflow) and mid-frame restarts (sync_err pulse).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_capture #(
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 4,
    parameter int ONES_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_en,
    input  logic                 frame_start,
    input  logic                 frame_ready,
    input  logic                 clear_ovf,
    output logic [FRAME_LEN-1:0] frame_data,
    output logic [ONES_W-1:0]    frame_ones,
    output logic                 frame_valid,
    output logic                 overflow,
    output logic                 sync_err
);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_IDX_ONE  = CNT_W'(1);

    state_t                 state_q;
    logic [CNT_W-1:0]       idx_q;
    logic [FRAME_LEN-1:0]   shift_q;
    logic [FRAME_LEN-1:0]   frame_data_q;
    logic [ONES_W-1:0]      frame_ones_q;
    logic                   frame_valid_q;
    logic                   overflow_q;
    logic                   sync_err_q;

    // Candidate completed word: collected bits with the final bit merged in
    logic [FRAME_LEN-1:0]   frame_word_d;
    logic [ONES_W-1:0]      frame_ones_d;
    logic                   buf_free;

    // Build the completed word and its popcount so both register together
    always_comb begin
        frame_word_d                = shift_q;
        frame_word_d[FRAME_LEN-1]   = bit_in;
        frame_ones_d                = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            frame_ones_d = frame_ones_d + ONES_W'(frame_word_d[i]);
        end
    end

    // Buffer can take a new frame if empty or being drained on this edge
    assign buf_free = !frame_valid_q || frame_ready;

    // Frame assembly FSM with registered output buffer and status flags.
    // Later assignments in this block intentionally override earlier ones
    // (completion overrides consume, overflow set overrides clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            idx_q         <= '0;
            shift_q       <= '0;
            frame_data_q  <= '0;
            frame_ones_q  <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;

            if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
            end

            if (clear_ovf) begin
                overflow_q <= 1'b0;
            end

            if (bit_en) begin
                case (state_q)
                    HUNT: begin
                        // Bits outside a frame are dropped until a start is seen
                        if (frame_start) begin
                            shift_q <= FRAME_LEN'(bit_in);
                            idx_q   <= c_IDX_ONE;
                            state_q <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (frame_start) begin
                            // Realign: the partial frame is abandoned
                            shift_q    <= FRAME_LEN'(bit_in);
                            idx_q      <= c_IDX_ONE;
                            sync_err_q <= 1'b1;
                        end else if (idx_q == c_LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= HUNT;
                            if (buf_free) begin
                                frame_data_q  <= frame_word_d;
                                frame_ones_q  <= frame_ones_d;
                                frame_valid_q <= 1'b1;
                            end else begin
                                // Old frame is kept; the new one is lost
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            shift_q[idx_q] <= bit_in;
                            idx_q          <= idx_q + c_IDX_ONE;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_ones  = frame_ones_q;
    assign frame_valid = frame_valid_q;
    assign overflow    = overflow_q;
    assign sync_err    = sync_err_q;

endmodule

`default_nettype wire
